// File: rtl/rgb_to_gray_reducer.sv
// rtl/rgb_to_gray_reducer.sv - reads 24-bit RGB beats from memory, writes 8-bit luma beats back
// Optional: define RGB2GRAY_CYCLE_COUNT_EN to add a busy-cycle counter readable at CSR addr4.
module rgb_to_gray_reducer #(
  parameter int NUM_BYTES = 64,
  parameter int n         = 512
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s0_write,
  input  logic          s0_read,
  input  logic [2:0]    s0_address,
  input  logic [63:0]   s0_writedata,
  output logic [63:0]   s0_readdata,
  output logic [47:0]   address,
  output logic          read,
  output logic          write,
  output logic [n-1:0]  writedata,
  input  logic [n-1:0]  readdata,
  input  logic          readdatavalid,
  input  logic          waitrequest
);

  localparam int          LB         = $clog2(NUM_BYTES);
  localparam logic [47:0] BEAT_BYTES = 48'(NUM_BYTES);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, CALC, WR_REQ, NEXT, FINISH} state_t;

  state_t        state, state_nx;
  logic [47:0]   src_q, dst_q, rd_addr, wr_addr;
  logic [31:0]   length_q, blk, blk_inc;
  logic [1:0]    beat;
  logic          busy, done;
  logic [n-1:0]  slot0, slot1, slot2, luma;
  logic [3*n-1:0] group;
  logic [63:0]   csr_rd;
  logic          start, start_job, last_blk;
  logic          unused_wdata;

  assign unused_wdata = ^s0_writedata[63:48];

  assign start     = s0_write && (s0_address == 3'd2) && !busy;
  assign start_job = start && (s0_writedata[31:LB] != '0);
  assign blk_inc   = blk + 32'd1;
  assign last_blk  = ({blk_inc, {LB{1'b0}}} == {{LB{1'b0}}, length_q});

  // Rounded fixed-point BT.601 weights; the weights sum to 256 so gray maps to itself.
  function automatic logic [7:0] luma8(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    logic [15:0] s;
    s = 16'd77 * {8'd0, r} + 16'd150 * {8'd0, g} + 16'd29 * {8'd0, b} + 16'd128;
    return s[15:8];
  endfunction

  assign group = {slot2, slot1, slot0};

  always_comb begin
    luma = '0;
    for (int k = 0; k < NUM_BYTES; k++)
      luma[8*k +: 8] = luma8(group[24*k +: 8], group[24*k+8 +: 8], group[24*k+16 +: 8]);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_job) state_nx = RD_REQ;
      RD_REQ:  if (!waitrequest) state_nx = RD_WAIT;
      RD_WAIT: if (readdatavalid) state_nx = (beat == 2'd2) ? CALC : RD_REQ;
      CALC:    state_nx = WR_REQ;
      WR_REQ:  if (!waitrequest) state_nx = NEXT;
      NEXT:    state_nx = last_blk ? FINISH : RD_REQ;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign read    = (state == RD_REQ);
  assign write   = (state == WR_REQ);
  assign address = read ? rd_addr : (write ? wr_addr : '0);

`ifdef RGB2GRAY_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cyc_cnt <= '0;
    else if (start)
      cyc_cnt <= '0;
    else if (busy && state != FINISH && cyc_cnt != '1)
      cyc_cnt <= cyc_cnt + 32'd1;
  end
`endif

  always_comb begin
    csr_rd = '0;
    case (s0_address)
      3'd0: csr_rd = {16'd0, src_q};
      3'd1: csr_rd = {16'd0, dst_q};
      3'd2: csr_rd = {32'd0, length_q};
      3'd3: csr_rd = {62'd0, busy, done};
`ifdef RGB2GRAY_CYCLE_COUNT_EN
      3'd4: csr_rd = {32'd0, cyc_cnt};
`endif
      default: csr_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      length_q    <= '0;
      rd_addr     <= '0;
      wr_addr     <= '0;
      blk         <= '0;
      beat        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      slot0       <= '0;
      slot1       <= '0;
      slot2       <= '0;
      writedata   <= '0;
      s0_readdata <= '0;
    end else begin
      state <= state_nx;
      if (s0_read)
        s0_readdata <= csr_rd;
      if (s0_write && !busy) begin
        case (s0_address)
          3'd0:    src_q    <= s0_writedata[47:0];
          3'd1:    dst_q    <= s0_writedata[47:0];
          3'd2:    length_q <= {s0_writedata[31:LB], {LB{1'b0}}};
          default: ;
        endcase
      end
      if (start) begin
        blk     <= '0;
        beat    <= '0;
        rd_addr <= src_q;
        wr_addr <= dst_q;
        busy    <= start_job;
        done    <= !start_job;
      end
      // Beats are consumed strictly in order, so the read pointer just steps by one beat.
      case (state)
        RD_REQ:  if (!waitrequest) rd_addr <= rd_addr + BEAT_BYTES;
        RD_WAIT: if (readdatavalid) begin
          case (beat)
            2'd0:    slot0 <= readdata;
            2'd1:    slot1 <= readdata;
            default: slot2 <= readdata;
          endcase
          if (beat != 2'd2)
            beat <= beat + 2'd1;
        end
        CALC:    writedata <= luma;
        WR_REQ:  if (!waitrequest) wr_addr <= wr_addr + BEAT_BYTES;
        NEXT: begin
          blk  <= blk_inc;
          beat <= '0;
        end
        FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_to_gray_reducer.sv
// tb/tb_rgb_to_gray_reducer.sv - scoreboard bench for rgb_to_gray_reducer with a memory slave model
module tb_rgb_to_gray_reducer;

  logic          clk = 1'b0;
  logic          reset;
  logic          s0_write, s0_read;
  logic [2:0]    s0_address;
  logic [63:0]   s0_writedata, s0_readdata;
  logic [47:0]   address;
  logic          read, write;
  logic [511:0]  writedata, readdata;
  logic          readdatavalid, waitrequest;

  rgb_to_gray_reducer #(.NUM_BYTES(64), .n(512)) dut (
    .clk(clk), .reset(reset),
    .s0_write(s0_write), .s0_read(s0_read), .s0_address(s0_address),
    .s0_writedata(s0_writedata), .s0_readdata(s0_readdata),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  logic [7:0]   mem [logic [47:0]];
  logic [47:0]  exp_rd[$], exp_wa[$];
  logic [511:0] exp_wd[$];
  int           n_rd = 0, n_wr = 0, w_cyc = 0;
  logic [511:0] last_wdata = '0;
  bit           stall_en = 0;
  int           lat_lo = 1, lat_hi = 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [63:0] d);
    s0_write = 1'b1; s0_address = a; s0_writedata = d;
    tick();
    s0_write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [63:0] d);
    s0_read = 1'b1; s0_address = a;
    tick();
    s0_read = 1'b0;
    d = s0_readdata;
  endtask

  task automatic fill(input logic [47:0] base, input int nbytes, input bit rnd, input logic [7:0] val);
    logic [47:0] a;
    for (int i = 0; i < nbytes; i++) begin
      a = base + 48'(i);
      mem[a] = rnd ? 8'($urandom) : val;
    end
  endtask

  // Reference: each output byte k is the luma of pixel k in its 192-byte RGB group.
  task automatic push_job(input logic [47:0] src, input logic [47:0] dst, input int nblk);
    logic [47:0]  a, a1, a2;
    logic [511:0] y;
    int r, g, b;
    for (int bl = 0; bl < nblk; bl++) begin
      for (int bt = 0; bt < 3; bt++)
        exp_rd.push_back(src + 48'(192*bl + 64*bt));
      for (int k = 0; k < 64; k++) begin
        a  = src + 48'(192*bl + 3*k);
        a1 = a + 48'd1;
        a2 = a + 48'd2;
        r = int'(mem[a]); g = int'(mem[a1]); b = int'(mem[a2]);
        y[8*k +: 8] = 8'((77*r + 150*g + 29*b + 128) / 256);
      end
      exp_wa.push_back(dst + 48'(64*bl));
      exp_wd.push_back(y);
    end
  endtask

  task automatic wait_done();
    logic [63:0] st;
    int t;
    st = '0;
    t = 0;
    while (!st[0] && t < 3000) begin
      csr_read(3'd3, st);
      t++;
    end
    chk("done_timeout", st[0], 1);
    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("wr_queue_empty", exp_wa.size(), 0);
  endtask

  // Memory slave and monitor: decides stalls, returns read data, checks every accepted transfer.
  initial begin
    logic [47:0]  aj, h_a;
    logic [511:0] rd_buf, h_d;
    logic [1:0]   h_ctl;
    int           rd_cnt, stall_left;
    bit           in_req;
    rd_cnt = 0; stall_left = 0; in_req = 0;
    rd_buf = '0; h_d = '0; h_a = '0; h_ctl = '0;
    waitrequest = 1'b0; readdatavalid = 1'b0; readdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      readdatavalid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          readdatavalid = 1'b1;
          readdata = rd_buf;
        end
      end
      if (read || write) begin
        if (!in_req) begin
          in_req = 1;
          stall_left = stall_en ? $urandom_range(0, 5) : 0;
          h_ctl = {read, write}; h_a = address; h_d = writedata;
        end else begin
          chk("stall_ctl", {read, write}, h_ctl);
          chk("stall_addr", address, h_a);
          if (write) chk("stall_wdata", writedata, h_d);
        end
        if (stall_left > 0) begin
          waitrequest = 1'b1;
          stall_left--;
        end else begin
          waitrequest = 1'b0;
          in_req = 0;
          if (read) begin
            n_rd++;
            if (exp_rd.size() == 0) chk("unexpected_read", address, 48'hBAD0BAD0BAD0);
            else chk("rd_addr", address, exp_rd.pop_front());
            for (int j = 0; j < 64; j++) begin
              aj = address + 48'(j);
              rd_buf[8*j +: 8] = mem.exists(aj) ? mem[aj] : 8'h00;
            end
            rd_cnt = $urandom_range(lat_hi, lat_lo);
          end else begin
            n_wr++;
            w_cyc = cyc;
            last_wdata = writedata;
            if (exp_wa.size() == 0) chk("unexpected_write", address, 48'hBAD0BAD0BAD0);
            else begin
              chk("wr_addr", address, exp_wa.pop_front());
              chk("wr_data", writedata, exp_wd.pop_front());
            end
          end
        end
      end else begin
        waitrequest = 1'b0;
        in_req = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    logic [47:0] src;
    int nr, nw, t, s_cyc;
    reset = 1'b1; s0_write = 1'b0; s0_read = 1'b0; s0_address = '0; s0_writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_address", address, 0);
    chk("rst_writedata", writedata, 0);
    chk("rst_readdata", s0_readdata, 0);
    csr_read(3'd3, v); chk("rst_status", v, 0);
    csr_read(3'd0, v); chk("rst_src", v, 0);
    csr_read(3'd4, v); chk("rst_addr4", v, 0);

    // gray round trip
    fill(48'h2000, 192, 0, 8'h5A);
    csr_write(3'd0, 64'h2000);
    csr_write(3'd1, 64'h1000);
    push_job(48'h2000, 48'h1000, 1);
    nr = n_rd; nw = n_wr;
    csr_write(3'd2, 64'd64);
    wait_done();
    chk("gray_nrd", n_rd - nr, 3);
    chk("gray_nwr", n_wr - nw, 1);
    chk("gray_data", last_wdata, {64{8'h5A}});
    csr_read(3'd3, v); chk("gray_status", v, 1);

    // colour math
    fill(48'h4000, 192, 0, 8'h00);
    mem[48'h4000] = 8'hFF;
    mem[48'h4004] = 8'hFF;
    mem[48'h4008] = 8'hFF;
    mem[48'h4009] = 8'hFF; mem[48'h400A] = 8'hFF; mem[48'h400B] = 8'hFF;
    csr_write(3'd0, 64'h4000);
    csr_write(3'd1, 64'h5000);
    push_job(48'h4000, 48'h5000, 1);
    csr_write(3'd2, 64'd64);
    wait_done();
    chk("colour_red", last_wdata[7:0], 8'h4D);
    chk("colour_green", last_wdata[15:8], 8'h95);
    chk("colour_blue", last_wdata[23:16], 8'h1D);
    chk("colour_white", last_wdata[31:24], 8'hFF);
    chk("colour_rest", last_wdata[511:32], 0);

    // multi-block with stalls and random pixels
    stall_en = 1; lat_lo = 2; lat_hi = 10;
    fill(48'h10000, 576, 1, 8'h00);
    csr_write(3'd0, 64'h10000);
    csr_write(3'd1, 64'h20000);
    push_job(48'h10000, 48'h20000, 3);
    nr = n_rd; nw = n_wr;
    csr_write(3'd2, 64'd192);
    wait_done();
    chk("multi_nrd", n_rd - nr, 9);
    chk("multi_nwr", n_wr - nw, 3);

    // zero length
    nr = n_rd; nw = n_wr;
    csr_write(3'd2, 64'd0);
    csr_read(3'd3, v); chk("zero_status", v, 1);
    repeat (5) tick();
    chk("zero_nrd", n_rd - nr, 0);
    chk("zero_nwr", n_wr - nw, 0);

    // writes while busy are ignored; length low bits are dropped
    fill(48'h30000, 384, 1, 8'h00);
    csr_write(3'd0, 64'h30000);
    csr_write(3'd1, 64'h3000);
    push_job(48'h30000, 48'h3000, 2);
    nr = n_rd; nw = n_wr;
    csr_write(3'd2, 64'hBF);
    csr_write(3'd1, 64'hDEAD);
    csr_write(3'd2, 64'd64);
    csr_write(3'd0, 64'h0);
    csr_read(3'd3, v); chk("busy_status", v, 2);
    wait_done();
    csr_read(3'd1, v); chk("busy_dst", v, 64'h3000);
    csr_read(3'd2, v); chk("busy_length", v, 64'd128);
    csr_read(3'd0, v); chk("busy_src", v, 64'h30000);
    chk("busy_nrd", n_rd - nr, 6);
    chk("busy_nwr", n_wr - nw, 2);

    // reset while waiting for read data; the late beat must be ignored
    stall_en = 0; lat_lo = 8; lat_hi = 8;
    fill(48'h40000, 192, 1, 8'h00);
    csr_write(3'd0, 64'h40000);
    csr_write(3'd1, 64'h6000);
    push_job(48'h40000, 48'h6000, 1);
    nr = n_rd;
    csr_write(3'd2, 64'd64);
    t = 0;
    while (n_rd == nr && t < 50) begin tick(); t++; end
    chk("rst_mid_first_read", n_rd - nr, 1);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_read", read, 0);
    chk("rst_mid_write", write, 0);
    chk("rst_mid_address", address, 0);
    chk("rst_mid_writedata", writedata, 0);
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    nw = n_wr;
    repeat (15) tick();
    chk("rst_mid_nwr", n_wr - nw, 0);
    csr_read(3'd3, v); chk("rst_mid_status", v, 0);
    csr_read(3'd0, v); chk("rst_mid_src", v, 0);

    // follow-up job whose source wraps past the top of the address space
    stall_en = 1; lat_lo = 2; lat_hi = 10;
    src = 48'hFFFF_FFFF_FFC0;
    fill(src, 192, 1, 8'h00);
    csr_write(3'd0, {16'd0, src});
    csr_write(3'd1, 64'h7000);
    push_job(src, 48'h7000, 1);
    nr = n_rd; nw = n_wr;
    csr_write(3'd2, 64'd64);
    wait_done();
    chk("wrap_nrd", n_rd - nr, 3);
    chk("wrap_nwr", n_wr - nw, 1);

    // cycle counter against measured busy cycles with a zero-latency slave
    stall_en = 0; lat_lo = 1; lat_hi = 1;
    fill(48'h50000, 192, 1, 8'h00);
    csr_write(3'd0, 64'h50000);
    csr_write(3'd1, 64'h8000);
    push_job(48'h50000, 48'h8000, 1);
    s_cyc = cyc;
    csr_write(3'd2, 64'd64);
    wait_done();
    csr_read(3'd4, v);
`ifdef RGB2GRAY_CYCLE_COUNT_EN
    chk("cyc_count", v, 64'(w_cyc - s_cyc + 1));
    chk("cyc_nonzero", v != 0, 1);
`else
    chk("cyc_count_off", v, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_to_gray_reducer.md
Name: rgb_to_gray_reducer

Overview:
- Downstream stage of the grayscale-to-RGB expander. Consumes the interleaved 24-bit RGB buffer it writes in host memory.
- Reads three 512-bit beats (64 RGB pixels), computes an 8-bit luma per pixel, and writes one 512-bit beat of grayscale to a destination buffer.
- Host-controlled through a 64-bit CSR slave (s0). Uses the same Avalon-MM master conventions: 48-bit byte address, 512-bit data.

Parameters:
- NUM_BYTES, 64, bytes per bus beat (grayscale pixels per output beat).
- n, 512, bus data width; must equal NUM_BYTES*8.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- s0_write  input  1  CSR write strobe
- s0_read  input  1  CSR read strobe
- s0_address  input  3  CSR word address
- s0_writedata  input  64  CSR write data
- s0_readdata  output  64  CSR read data, registered
- address  output  48  master byte address
- read  output  1  master read request
- write  output  1  master write request
- writedata  output  n  master write data
- readdata  input  n  master read data
- readdatavalid  input  1  read data valid
- waitrequest  input  1  slave stall

Behaviour:
- Reset: clk is the only clock; reset is synchronous, active-high. At reset, every output is 0, state is IDLE, and all CSRs, busy and done are 0.
- CSR map:
  - addr0: src address [47:0], R/W.
  - addr1: dst address [47:0], R/W.
  - addr2: length in output bytes [31:0], R/W. A write also starts the job.
  - addr3: status, RO; {62'b0, busy, done}.
  - addr4: cycle count, RO (see Optional Feature).
  - Any other address reads 0.
- CSR timing and write rules:
  - Reads return on s0_readdata in the cycle after s0_read is high; s0_readdata holds otherwise.
  - Writes to addr0–2 while busy are ignored entirely, including the start.
  - length[5:0] is forced to 0 on write, so length is always a multiple of NUM_BYTES.
- Start: a write to addr2 while idle sets busy=1, clears done and clears the block counter blk (32-bit).
  - If the written length is 0: busy is never set, done=1 on the next cycle, and no bus traffic occurs.
- FSM states: IDLE, RD_REQ, RD_WAIT, CALC, WR_REQ, NEXT, FINISH.
- IDLE → RD_REQ on start with beat=0.
- RD_REQ:
  - read=1, address = src + 192*blk + 64*beat.
  - Hold while waitrequest=1; on !waitrequest go to RD_WAIT with read=0 the following cycle.
- RD_WAIT:
  - On readdatavalid, capture readdata into beat slot [beat]. Slot 0 holds bytes 0–63 of the 192-byte group, slot 2 holds bytes 128–191.
  - If beat<2: beat++ and go to RD_REQ. Otherwise go to CALC.
  - Only one read is outstanding at a time.
- Pixel format: group byte 3k=R, 3k+1=G, 3k+2=B for pixel k (0..63), little-endian byte lanes (byte j = data[8j+7:8j]).
- CALC (1 cycle):
  - Y_k = (77*R + 150*G + 29*B + 128) >> 8, computed in 16-bit unsigned. The maximum result is 255, so no saturation is needed.
  - Gray input (R=G=B=g) yields Y=g exactly.
  - Y_k goes to writedata byte k, registered.
- WR_REQ:
  - write=1, address = dst + 64*blk.
  - writedata, address and write are held stable while waitrequest=1; on !waitrequest write=0 the next cycle.
- NEXT: blk++. If 64*blk == length, go to FINISH; otherwise go to RD_REQ with beat=0.
- FINISH: busy=0, done=1, go to IDLE. done stays 1 until the next accepted start or reset.
- Address arithmetic: 48-bit, wraps modulo 2^48, no alignment checks. Hosts supply 64-byte-aligned src/dst.
- Reset mid-job:
  - read/write drop the same cycle reset is sampled, and state returns to IDLE.
  - A late readdatavalid arriving in IDLE is ignored.
- Simultaneous s0_read and s0_write are allowed. A read of addr3 in the same cycle as an accepted start returns the pre-start status.

Optional Feature:
- Macro: RGB2GRAY_CYCLE_COUNT_EN.
- Defined: a 32-bit counter clears on accepted start and increments every cycle while busy. It freezes at FINISH, saturates at 0xFFFFFFFF, and reads at addr4 in bits [31:0].
- Undefined: no counter logic; addr4 reads 0.

Test Plan:
- Gray round trip:
  - Stimulus: src buffer of 192 bytes all 0x5A, dst=0x1000, length=64, no waitrequest.
  - Required response: exactly 3 reads (addresses src, src+64, src+128) then 1 write to 0x1000 with all bytes 0x5A; status then reads 0x1.
- Colour math:
  - Stimulus: pixel0 (255,0,0), pixel1 (0,255,0), pixel2 (0,0,255), pixel3 (255,255,255), rest 0.
  - Required response: written bytes 0..3 = 0x4D, 0x95, 0x1D, 0xFF; others 0x00.
- Multi-block with stalls:
  - Stimulus: length=192 (3 blocks), random waitrequest 0–5 cycles, readdatavalid 2–10 cycles after acceptance.
  - Required response: 9 reads at src+0..src+512 in 64-byte steps and 3 writes at dst, dst+64, dst+128. read/write/address/writedata stable during every stall.
- Zero length and busy:
  - Stimulus: a length=0 start.
  - Required response: done=1 one cycle later with no read/write.
  - Stimulus: during a length=128 job, write addr1=0xDEAD then a second start.
  - Required response: both writes ignored; dst and length unchanged on readback.
- Reset mid-job:
  - Stimulus: reset asserted while in RD_WAIT, then readdatavalid pulsed afterwards.
  - Required response: outputs 0, status 0, and the late data causes no write. A subsequent job completes correctly.
- Cycle count (macro defined):
  - Stimulus: length=64 with zero-latency slave.
  - Required response: addr4 reads a nonzero constant that matches the measured busy cycles exactly.
  - Macro undefined: addr4 reads 0.
